// File: rtl/register_jk_counter.sv
// Bank of WIDTH JK flip-flops that doubles as a modulo-MODULUS up/down counter.
// Optional macro REGISTER_JK_COUNTER_DOWN_EN builds the down-count path; without it count mode only counts up.
module register_jk_counter #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned MODULUS = 2 ** WIDTH,
   parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             mode,
   input  logic             direction,
   input  logic [WIDTH-1:0] jack,
   input  logic [WIDTH-1:0] kilby,
   output logic [WIDTH-1:0] signal_q,
   output logic [WIDTH-1:0] signal_q_,
   output logic             carry
);

   localparam logic [WIDTH-1:0] TOP_VAL = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] state_q;
   logic [WIDTH-1:0] state_d;
   logic [WIDTH-1:0] up_next_s;
   logic             up_wrap_s;
   logic             carry_s;
`ifdef REGISTER_JK_COUNTER_DOWN_EN
   logic [WIDTH-1:0] down_next_s;
   logic             down_wrap_s;
`else
   logic             unused_direction_s;
   assign unused_direction_s = direction;
`endif

   // Count-mode successor values; anything at or above the top wraps to zero going up.
   always_comb begin
      up_wrap_s = (state_q >= TOP_VAL);
      if (up_wrap_s) begin
         up_next_s = {WIDTH{1'b0}};
      end else begin
         up_next_s = state_q + WIDTH'(1);
      end
`ifdef REGISTER_JK_COUNTER_DOWN_EN
      // Out-of-range values clamp to the top so the counter re-enters its range.
      down_wrap_s = (state_q == {WIDTH{1'b0}});
      if (down_wrap_s || (state_q > TOP_VAL)) begin
         down_next_s = TOP_VAL;
      end else begin
         down_next_s = state_q - WIDTH'(1);
      end
`endif
   end

   // Next-state selection and terminal-count flag.
   always_comb begin
      state_d = state_q;
      carry_s = 1'b0;
      if (reset) begin
         state_d = RESET_VALUE;
         carry_s = 1'b0;
      end else if (!enable) begin
         state_d = state_q;
         carry_s = 1'b0;
      end else if (mode) begin
`ifdef REGISTER_JK_COUNTER_DOWN_EN
         if (direction) begin
            state_d = up_next_s;
            carry_s = up_wrap_s;
         end else begin
            state_d = down_next_s;
            carry_s = down_wrap_s;
         end
`else
         state_d = up_next_s;
         carry_s = up_wrap_s;
`endif
      end else begin
         // Characteristic JK equation: Q+ = J&~Q | ~K&Q, applied bitwise.
         state_d = (jack & ~state_q) | (~kilby & state_q);
         carry_s = 1'b0;
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= RESET_VALUE;
      end else begin
         state_q <= state_d;
      end
   end

   assign signal_q  = state_q;
   assign signal_q_ = ~state_q;
   assign carry     = carry_s;

endmodule

// File: tb/tb_register_jk_counter.sv
// Directed bench for register_jk_counter (WIDTH=4, MODULUS=10, RESET_VALUE=4'hA).
// Expectations follow REGISTER_JK_COUNTER_DOWN_EN the same way the design build does.
module tb_register_jk_counter;

   logic       clock;
   logic       reset;
   logic       enable;
   logic       mode;
   logic       direction;
   logic [3:0] jack;
   logic [3:0] kilby;
   logic [3:0] signal_q;
   logic [3:0] signal_q_;
   logic       carry;

   int n_cmp;
   int n_fail;

   register_jk_counter #(
      .WIDTH(4),
      .MODULUS(10),
      .RESET_VALUE(4'hA)
   ) dut (
      .clock(clock),
      .reset(reset),
      .enable(enable),
      .mode(mode),
      .direction(direction),
      .jack(jack),
      .kilby(kilby),
      .signal_q(signal_q),
      .signal_q_(signal_q_),
      .carry(carry)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Loads an arbitrary value through JK mode (J=v, K=~v sets/clears every bit).
   task automatic jk_load(input logic [3:0] v);
      reset = 1'b0; enable = 1'b1; mode = 1'b0;
      jack = v; kilby = ~v;
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b1; mode = 1'b1; direction = 1'b1;
      jack = 4'h0; kilby = 4'h0;
      tick();
      #1;
      n_cmp++; if (signal_q !== 4'hA) begin n_fail++; $display("FAIL reset_q got %h want %h", signal_q, 4'hA); end
      n_cmp++; if (signal_q_ !== 4'h5) begin n_fail++; $display("FAIL reset_qn got %h want %h", signal_q_, 4'h5); end
      n_cmp++; if (carry !== 1'b0) begin n_fail++; $display("FAIL reset_carry got %b want 0", carry); end
      jk_load(4'h3);
      n_cmp++; if (signal_q !== 4'h3) begin n_fail++; $display("FAIL reset_preload got %h want %h", signal_q, 4'h3); end
      reset = 1'b1; enable = 1'b0;
      tick();
      n_cmp++; if (signal_q !== 4'hA) begin n_fail++; $display("FAIL reset_en0 got %h want %h", signal_q, 4'hA); end
      reset = 1'b0;
   endtask

   task automatic test_jk();
      jk_load(4'b0101);
      jack = 4'b1100; kilby = 4'b1010;
      #1;
      n_cmp++; if (carry !== 1'b0) begin n_fail++; $display("FAIL jk_carry got %b want 0", carry); end
      tick();
      n_cmp++; if (signal_q !== 4'b1101) begin n_fail++; $display("FAIL jk_q got %b want %b", signal_q, 4'b1101); end
      n_cmp++; if (signal_q_ !== 4'b0010) begin n_fail++; $display("FAIL jk_qn got %b want %b", signal_q_, 4'b0010); end
   endtask

   task automatic test_count_up();
      logic [3:0] exp_q;
      jk_load(4'h0);
      mode = 1'b1; direction = 1'b1; jack = 4'hF; kilby = 4'hF;
      for (int i = 0; i < 12; i++) begin
         #1;
         n_cmp++;
         if (carry !== (i == 9)) begin n_fail++; $display("FAIL up_carry[%0d] got %b want %b", i, carry, (i == 9)); end
         tick();
         exp_q = 4'((i + 1) % 10);
         n_cmp++;
         if (signal_q !== exp_q) begin n_fail++; $display("FAIL up_q[%0d] got %h want %h", i, signal_q, exp_q); end
      end
   endtask

   task automatic test_count_down();
      jk_load(4'h0);
      mode = 1'b1; direction = 1'b0;
      #1;
`ifdef REGISTER_JK_COUNTER_DOWN_EN
      n_cmp++; if (carry !== 1'b1) begin n_fail++; $display("FAIL dn_carry0 got %b want 1", carry); end
      tick();
      n_cmp++; if (signal_q !== 4'h9) begin n_fail++; $display("FAIL dn_wrap got %h want 9", signal_q); end
`else
      n_cmp++; if (carry !== 1'b0) begin n_fail++; $display("FAIL dn_carry0 got %b want 0", carry); end
      tick();
      n_cmp++; if (signal_q !== 4'h1) begin n_fail++; $display("FAIL dn_wrap got %h want 1", signal_q); end
`endif
      jk_load(4'hF);
      mode = 1'b1; direction = 1'b0;
      #1;
`ifdef REGISTER_JK_COUNTER_DOWN_EN
      n_cmp++; if (carry !== 1'b0) begin n_fail++; $display("FAIL dn_carryF got %b want 0", carry); end
      tick();
      n_cmp++; if (signal_q !== 4'h9) begin n_fail++; $display("FAIL dn_clamp got %h want 9", signal_q); end
      tick();
      n_cmp++; if (signal_q !== 4'h8) begin n_fail++; $display("FAIL dn_step got %h want 8", signal_q); end
`else
      n_cmp++; if (carry !== 1'b1) begin n_fail++; $display("FAIL dn_carryF got %b want 1", carry); end
      tick();
      n_cmp++; if (signal_q !== 4'h0) begin n_fail++; $display("FAIL dn_clamp got %h want 0", signal_q); end
      tick();
      n_cmp++; if (signal_q !== 4'h1) begin n_fail++; $display("FAIL dn_step got %h want 1", signal_q); end
`endif
   endtask

   task automatic test_hold_and_reset();
      jk_load(4'h9);
      mode = 1'b1; direction = 1'b1; enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++; if (carry !== 1'b0) begin n_fail++; $display("FAIL hold_carry[%0d] got %b want 0", i, carry); end
         tick();
         n_cmp++; if (signal_q !== 4'h9) begin n_fail++; $display("FAIL hold_q[%0d] got %h want 9", i, signal_q); end
      end
      reset = 1'b1; enable = 1'b1;
      #1;
      n_cmp++; if (carry !== 1'b0) begin n_fail++; $display("FAIL rst_carry got %b want 0", carry); end
      reset = 1'b0;
      jk_load(4'h5);
      mode = 1'b1; direction = 1'b1;
      tick();
      tick();
      n_cmp++; if (signal_q !== 4'h7) begin n_fail++; $display("FAIL mid_pre got %h want 7", signal_q); end
      reset = 1'b1;
      tick();
      n_cmp++; if (signal_q !== 4'hA) begin n_fail++; $display("FAIL mid_reset got %h want A", signal_q); end
      reset = 1'b0;
      #1;
      n_cmp++; if (carry !== 1'b1) begin n_fail++; $display("FAIL mid_carry got %b want 1", carry); end
      tick();
      n_cmp++; if (signal_q !== 4'h0) begin n_fail++; $display("FAIL mid_resume got %h want 0", signal_q); end
   endtask

   task automatic test_mode_switch();
      logic [3:0] exp_seq [6];
      exp_seq = '{4'h6, 4'h7, 4'h8, 4'h9, 4'h6, 4'h7};
      jk_load(4'h9);
      jack = 4'hF; kilby = 4'hF; direction = 1'b1; enable = 1'b1;
      for (int i = 0; i < 6; i++) begin
         mode = (i % 2 == 1);
         tick();
         n_cmp++;
         if (signal_q !== exp_seq[i]) begin n_fail++; $display("FAIL msw_q[%0d] got %h want %h", i, signal_q, exp_seq[i]); end
      end
   endtask

   initial begin
      n_cmp = 0;
      n_fail = 0;
      reset = 1'b1; enable = 1'b0; mode = 1'b0; direction = 1'b1;
      jack = 4'h0; kilby = 4'h0;
      tick();
      test_reset();
      test_jk();
      test_count_up();
      test_count_down();
      test_hold_and_reset();
      test_mode_switch();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
